// File: rtl/mips_multicycle.sv
// mips_multicycle: non-pipelined 32-bit MIPS-subset core. Every instruction
// takes exactly five cycles (IF, ID, EX, ME, WB); PC and register file are
// only updated on the WB->IF edge, so an asynchronous reset at any point
// leaves no partial architectural effect.
//
// phase | meaning
// IF    | instruction word presented on instr_in, captured into IR at end
// ID    | rs/rt operands read from the register file
// EX    | ALU result, next PC and memory address computed
// ME    | load/store access on the data port (write strobe only for SW)
// WB    | register write and PC update on the closing edge
module mips_multicycle #(
  parameter logic [31:0] pc_init = 32'h8002_0000,
  parameter logic [31:0] sp_init = 32'h8012_0000,
  parameter logic [31:0] ra_init = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_in,
  output logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_rd_wr
);

  typedef enum logic [2:0] {PH_IF, PH_ID, PH_EX, PH_ME, PH_WB} phase_t;

  phase_t      r_phase;
  phase_t      w_phase_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_alu;
  logic [31:0] r_npc;
  logic [31:0] r_mdr;
  logic [31:0] r_regs [32];

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_sh;
  logic [31:0] w_sext;
  logic [31:0] w_zext;
  logic [31:0] w_pc4;

  logic [31:0] w_alu;
  logic [31:0] w_npc;
  logic        w_wr;
  logic [4:0]  w_dst;
  logic        w_is_lw;
  logic        w_is_sw;

  // Probed by name from the bench.
  logic        st_en;
  logic        reg_wr_en;
  logic [4:0]  reg_wr_num;
  logic [31:0] reg_wr_data;

  assign w_op   = r_ir[31:26];
  assign w_rs   = r_ir[25:21];
  assign w_rt   = r_ir[20:16];
  assign w_rd   = r_ir[15:11];
  assign w_sh   = r_ir[10:6];
  assign w_fn   = r_ir[5:0];
  assign w_sext = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_zext = {16'h0000, r_ir[15:0]};
  assign w_pc4  = r_pc + 32'd4;

  assign instr_addr  = r_pc;
  assign st_en       = (r_phase == PH_ME) && w_is_sw;
  assign reg_wr_en   = (r_phase == PH_WB) && w_wr && (w_dst != 5'd0);
  assign reg_wr_num  = w_dst;
  assign reg_wr_data = w_is_lw ? r_mdr : r_alu;

  // Phase register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_phase <= PH_IF;
    else        r_phase <= w_phase_nxt;
  end

  // Fixed five-step rotation regardless of opcode.
  always_comb begin
    w_phase_nxt = PH_IF;
    case (r_phase)
      PH_IF:   w_phase_nxt = PH_ID;
      PH_ID:   w_phase_nxt = PH_EX;
      PH_EX:   w_phase_nxt = PH_ME;
      PH_ME:   w_phase_nxt = PH_WB;
      PH_WB:   w_phase_nxt = PH_IF;
      default: w_phase_nxt = PH_IF;
    endcase
  end

  // Decode and execute; unrecognised encodings fall through as NOP.
  always_comb begin
    w_alu   = 32'h0;
    w_npc   = w_pc4;
    w_wr    = 1'b0;
    w_dst   = w_rd;
    w_is_lw = 1'b0;
    w_is_sw = 1'b0;
    case (w_op)
      6'h00: begin
        w_wr = 1'b1;
        case (w_fn)
          6'h00:        w_alu = r_b << w_sh;
          6'h02:        w_alu = r_b >> w_sh;
          6'h03:        w_alu = $unsigned($signed(r_b) >>> w_sh);
          6'h20, 6'h21: w_alu = r_a + r_b;
          6'h22, 6'h23: w_alu = r_a - r_b;
          6'h24:        w_alu = r_a & r_b;
          6'h25:        w_alu = r_a | r_b;
          6'h26:        w_alu = r_a ^ r_b;
          6'h27:        w_alu = ~(r_a | r_b);
          6'h2A:        w_alu = {31'h0, $signed(r_a) < $signed(r_b)};
          6'h2B:        w_alu = {31'h0, r_a < r_b};
          6'h08: begin
            w_wr  = 1'b0;
            w_npc = r_a;
          end
          6'h09: begin
            w_alu = w_pc4;
            w_npc = r_a;
          end
          default:      w_wr = 1'b0;
        endcase
      end
      6'h09: begin w_alu = r_a + w_sext; w_wr = 1'b1; w_dst = w_rt; end
      6'h0A: begin w_alu = {31'h0, $signed(r_a) < $signed(w_sext)}; w_wr = 1'b1; w_dst = w_rt; end
      6'h0B: begin w_alu = {31'h0, r_a < w_sext}; w_wr = 1'b1; w_dst = w_rt; end
      6'h0C: begin w_alu = r_a & w_zext; w_wr = 1'b1; w_dst = w_rt; end
      6'h0D: begin w_alu = r_a | w_zext; w_wr = 1'b1; w_dst = w_rt; end
      6'h0E: begin w_alu = r_a ^ w_zext; w_wr = 1'b1; w_dst = w_rt; end
      6'h0F: begin w_alu = {r_ir[15:0], 16'h0000}; w_wr = 1'b1; w_dst = w_rt; end
      6'h23: begin w_alu = r_a + w_sext; w_wr = 1'b1; w_dst = w_rt; w_is_lw = 1'b1; end
      6'h2B: begin w_alu = r_a + w_sext; w_is_sw = 1'b1; end
      6'h04: if (r_a == r_b) w_npc = w_pc4 + (w_sext << 2);
      6'h05: if (r_a != r_b) w_npc = w_pc4 + (w_sext << 2);
      6'h02: w_npc = {w_pc4[31:28], r_ir[25:0], 2'b00};
      6'h03: begin
        w_npc = {w_pc4[31:28], r_ir[25:0], 2'b00};
        w_alu = w_pc4;
        w_wr  = 1'b1;
        w_dst = 5'd31;
      end
      default: ;
    endcase
  end

  // Datapath registers and data-port outputs, advanced phase by phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= pc_init;
      r_ir       <= 32'h0;
      r_a        <= 32'h0;
      r_b        <= 32'h0;
      r_alu      <= 32'h0;
      r_npc      <= pc_init;
      r_mdr      <= 32'h0;
      data_addr  <= 32'h0;
      data_out   <= 32'h0;
      data_rd_wr <= 1'b1;
    end else begin
      case (r_phase)
        PH_IF: r_ir <= instr_in;
        PH_ID: begin
          r_a <= r_regs[w_rs];
          r_b <= r_regs[w_rt];
        end
        PH_EX: begin
          r_alu      <= w_alu;
          r_npc      <= w_npc;
          data_rd_wr <= ~w_is_sw;
          if (w_is_lw || w_is_sw) begin
            data_addr <= w_alu;
            data_out  <= r_b;
          end
        end
        PH_ME: begin
          r_mdr      <= data_in;
          data_rd_wr <= 1'b1;
        end
        PH_WB: r_pc <= r_npc;
        default: ;
      endcase
    end
  end

  // Register file; r0 is never written, so it always reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
      r_regs[29] <= sp_init;
      r_regs[31] <= ra_init;
    end else if (reg_wr_en) begin
      r_regs[reg_wr_num] <= reg_wr_data;
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: drives one instruction per five cycles, predicts each
// instruction's architectural effect with an ISA-level interpreter, and
// compares fetch address, data-port activity and register writes.
module tb_mips_multicycle;

  localparam logic [31:0] PC_INIT = 32'h8002_0000;
  localparam logic [31:0] SP_INIT = 32'h8012_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_addr;
  logic [31:0] instr_in = 32'h0;
  logic [31:0] data_addr;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        data_rd_wr;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] m_mem [logic [29:0]];
  logic [31:0] e_mem [logic [29:0]];

  logic        x_wr, x_ld, x_st;
  logic [4:0]  x_num;
  logic [31:0] x_data, x_addr, x_sdata, x_npc;

  mips_multicycle dut (
    .clk        (clk),
    .reset      (reset),
    .instr_addr (instr_addr),
    .instr_in   (instr_in),
    .data_addr  (data_addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_rd_wr (data_rd_wr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (pc %h)", tag, obs, exp, m_pc);
    end
  endtask

  function automatic logic [31:0] mem_default(input logic [29:0] k);
    return ({k, 2'b01} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] env_read(input logic [31:0] a);
    if (e_mem.exists(a[31:2])) return e_mem[a[31:2]];
    return mem_default(a[31:2]);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (m_mem.exists(a[31:2])) return m_mem[a[31:2]];
    return mem_default(a[31:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_regs[29] = SP_INIT;
    m_pc = PC_INIT;
  endtask

  // Architectural effect of one instruction; memory writes are committed later.
  task automatic model_exec(input logic [31:0] ins);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, dst;
    logic [31:0] a, b, se, ze, p4, val;
    logic        wr;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];
    a  = m_regs[rs]; b = m_regs[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    p4 = m_pc + 32'd4;
    x_npc = p4; wr = 1'b0; dst = rt; val = 32'h0;
    x_ld = 1'b0; x_st = 1'b0; x_addr = 32'h0; x_sdata = 32'h0;
    case (op)
      6'h00: begin
        dst = rd; wr = 1'b1;
        case (fn)
          6'h00: val = b << sh;
          6'h02: val = b >> sh;
          6'h03: val = $unsigned($signed(b) >>> sh);
          6'h20, 6'h21: val = a + b;
          6'h22, 6'h23: val = a - b;
          6'h24: val = a & b;
          6'h25: val = a | b;
          6'h26: val = a ^ b;
          6'h27: val = ~(a | b);
          6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: val = (a < b) ? 32'd1 : 32'd0;
          6'h08: begin wr = 1'b0; x_npc = a; end
          6'h09: begin val = p4; x_npc = a; end
          default: wr = 1'b0;
        endcase
      end
      6'h09: begin wr = 1'b1; val = a + se; end
      6'h0A: begin wr = 1'b1; val = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
      6'h0B: begin wr = 1'b1; val = (a < se) ? 32'd1 : 32'd0; end
      6'h0C: begin wr = 1'b1; val = a & ze; end
      6'h0D: begin wr = 1'b1; val = a | ze; end
      6'h0E: begin wr = 1'b1; val = a ^ ze; end
      6'h0F: begin wr = 1'b1; val = ze << 16; end
      6'h23: begin wr = 1'b1; x_ld = 1'b1; x_addr = a + se; val = model_read(x_addr); end
      6'h2B: begin x_st = 1'b1; x_addr = a + se; x_sdata = b; end
      6'h04: if (a == b) x_npc = p4 + (se << 2);
      6'h05: if (a != b) x_npc = p4 + (se << 2);
      6'h02: x_npc = {p4[31:28], ins[25:0], 2'b00};
      6'h03: begin
        x_npc = {p4[31:28], ins[25:0], 2'b00};
        wr = 1'b1; dst = 5'd31; val = p4;
      end
      default: ;
    endcase
    x_wr   = wr && (dst != 5'd0);
    x_num  = dst;
    x_data = val;
    if (x_wr) m_regs[dst] = val;
  endtask

  // Entered at a negedge with the DUT in IF; leaves at the next IF negedge.
  task automatic run_instr(input logic [31:0] ins, input bit abort_me);
    logic [31:0] pc_now;
    bit aborted;
    pc_now  = m_pc;
    aborted = 1'b0;
    instr_in = ins;
    model_exec(ins);
    for (int ph = 0; ph < 5 && !aborted; ph++) begin
      check_eq("instr_addr", instr_addr, pc_now);
      check_eq("st_en", 32'(dut.st_en), 32'(ph == 3 && x_st));
      check_eq("data_rd_wr", 32'(data_rd_wr), 32'(!(ph == 3 && x_st)));
      check_eq("reg_wr_en", 32'(dut.reg_wr_en), 32'(ph == 4 && x_wr));
      if (ph == 3 && (x_ld || x_st)) check_eq("data_addr", data_addr, x_addr);
      if (ph == 3 && x_st) check_eq("data_out", data_out, x_sdata);
      if (ph == 4 && x_wr) begin
        check_eq("reg_wr_num", 32'(dut.reg_wr_num), 32'(x_num));
        check_eq("reg_wr_data", dut.reg_wr_data, x_data);
      end
      if (ph == 3) begin
        data_in = env_read(data_addr);
        if (abort_me) begin
          reset = 1'b0;
          #1;
          check_eq("abort_st_en", 32'(dut.st_en), 32'd0);
          check_eq("abort_rd_wr", 32'(data_rd_wr), 32'd1);
          check_eq("abort_pc", instr_addr, PC_INIT);
          check_eq("abort_daddr", data_addr, 32'h0);
          check_eq("abort_wr_en", 32'(dut.reg_wr_en), 32'd0);
          model_reset();
          @(negedge clk);
          reset = 1'b1;
          aborted = 1'b1;
        end else begin
          if (!data_rd_wr) e_mem[data_addr[31:2]] = data_out;
          if (x_st) m_mem[x_addr[31:2]] = x_sdata;
        end
      end
      if (!aborted) @(negedge clk);
    end
    if (!aborted) m_pc = x_npc;
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 9);
    if (r == 8) return 5'd29;
    if (r == 9) return 5'd31;
    return 5'(r);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] ins;
    int k;
    k = $urandom_range(0, 29);
    rs = pick_reg(); rt = pick_reg(); rd = pick_reg();
    sh = 5'($urandom); imm = 16'($urandom); tgt = 26'($urandom);
    case (k)
      0:  ins = {6'h00, rs, rt, rd, sh, 6'h00};
      1:  ins = {6'h00, rs, rt, rd, sh, 6'h02};
      2:  ins = {6'h00, rs, rt, rd, sh, 6'h03};
      3:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h21};
      4:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      5:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h23};
      6:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      7:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h24};
      8:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      9:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h26};
      10: ins = {6'h00, rs, rt, rd, 5'd0, 6'h27};
      11: ins = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      12: ins = {6'h00, rs, rt, rd, 5'd0, 6'h2B};
      13: ins = {6'h00, rs, 15'd0, 6'h08};
      14: ins = {6'h00, rs, 5'd0, rd, 5'd0, 6'h09};
      15: ins = {6'h09, rs, rt, imm};
      16: ins = {6'h0A, rs, rt, imm};
      17: ins = {6'h0B, rs, rt, imm};
      18: ins = {6'h0C, rs, rt, imm};
      19: ins = {6'h0D, rs, rt, imm};
      20: ins = {6'h0E, rs, rt, imm};
      21: ins = {6'h0F, rs, rt, imm};
      22: ins = {6'h23, rs, rt, imm};
      23: ins = {6'h2B, rs, rt, imm};
      24: ins = {6'h04, rs, rt, imm};
      25: ins = {6'h05, rs, rt, imm};
      26: ins = {6'h02, tgt};
      27: ins = {6'h03, tgt};
      28: ins = {6'h3F, rs, rt, imm};
      default: ins = {6'h00, rs, rt, rd, 5'd0, 6'h3F};
    endcase
    return ins;
  endfunction

  initial begin
    model_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_pc", instr_addr, PC_INIT);
    check_eq("rst_rd_wr", 32'(data_rd_wr), 32'd1);
    check_eq("rst_daddr", data_addr, 32'h0);
    check_eq("rst_dout", data_out, 32'h0);
    check_eq("rst_st_en", 32'(dut.st_en), 32'd0);
    check_eq("rst_wr_en", 32'(dut.reg_wr_en), 32'd0);
    reset = 1'b1;

    run_instr(32'h1000_0002, 1'b0);                          // BEQ r0,r0,+2
    check_eq("beq_pc", instr_addr, 32'h8002_000C);
    run_instr({6'h02, 26'h000_8000}, 1'b0);                  // J 0x80020000
    run_instr(32'h1400_0002, 1'b0);                          // BNE r0,r0,+2
    check_eq("bne_pc", instr_addr, 32'h8002_0004);
    run_instr({6'h00, 5'd29, 5'd0, 5'd6, 5'd0, 6'h21}, 1'b0); // ADDU r6,r29,r0
    run_instr({6'h00, 5'd31, 5'd0, 5'd7, 5'd0, 6'h21}, 1'b0); // ADDU r7,r31,r0
    run_instr({6'h09, 5'd0, 5'd2, 16'h1234}, 1'b0);          // ADDIU r2,r0,0x1234
    run_instr({6'h00, 5'd2, 5'd2, 5'd3, 5'd0, 6'h21}, 1'b0);  // ADDU r3,r2,r2
    run_instr({6'h0F, 5'd0, 5'd4, 16'h8003}, 1'b0);          // LUI r4,0x8003
    run_instr({6'h0D, 5'd4, 5'd4, 16'h0010}, 1'b0);          // ORI r4,r4,0x10
    run_instr({6'h2B, 5'd4, 5'd3, 16'h0000}, 1'b0);          // SW r3,0(r4)
    run_instr({6'h23, 5'd4, 5'd5, 16'h0000}, 1'b0);          // LW r5,0(r4)
    run_instr({6'h02, 26'h000_8004}, 1'b0);                  // J 0x80020010
    run_instr({6'h03, 26'h000_8040}, 1'b0);                  // JAL 0x80020100
    check_eq("jal_pc", instr_addr, 32'h8002_0100);
    run_instr({6'h00, 5'd31, 15'd0, 6'h08}, 1'b0);           // JR r31
    check_eq("jr_pc", instr_addr, 32'h8002_0014);
    run_instr({6'h09, 5'd0, 5'd0, 16'h0005}, 1'b0);          // ADDIU r0,r0,5
    run_instr(32'hFC00_0000, 1'b0);                          // unknown opcode

    for (int n = 0; n < 400; n++) run_instr(gen_instr(), 1'b0);

    run_instr({6'h0F, 5'd0, 5'd4, 16'h8003}, 1'b0);
    run_instr({6'h0D, 5'd4, 5'd4, 16'h0040}, 1'b0);
    run_instr({6'h09, 5'd0, 5'd3, 16'h0077}, 1'b0);
    run_instr({6'h2B, 5'd4, 5'd3, 16'h0000}, 1'b1);          // SW aborted by reset
    check_eq("post_abort_pc", instr_addr, PC_INIT);
    run_instr({6'h00, 5'd29, 5'd0, 5'd6, 5'd0, 6'h21}, 1'b0);
    run_instr({6'h0F, 5'd0, 5'd4, 16'h8003}, 1'b0);
    run_instr({6'h0D, 5'd4, 5'd4, 16'h0040}, 1'b0);
    run_instr({6'h23, 5'd4, 5'd5, 16'h0000}, 1'b0);          // LW sees no store

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle.md
Name: mips_multicycle

Overview:
- Non-pipelined 32-bit MIPS-subset processor. Each instruction passes through five one-cycle phases: IF, ID, EX, ME, WB.
- Connects to an external instruction memory and an external data memory, both word-wide, at the top of the simulation/SoC.
- Contains PC, instruction register, 32x32 register file, ALU and phase sequencer.

Parameters:
pc_init, 32'h8002_0000, PC value after reset
sp_init, 32'h8012_0000, r29 (sp) value after reset
ra_init, 32'h0000_0000, r31 (ra) value after reset

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  asynchronous, active-low reset
instr_addr  output  32  instruction fetch address (= PC)
instr_in  input  32  instruction word from instruction memory
data_addr  output  32  data memory byte address
data_in  input  32  load data from data memory
data_out  output  32  store data to data memory
data_rd_wr  output  1  1 = read, 0 = write

Behaviour:
- Reset (reset low, asynchronous):
  - phase = IF; PC = pc_init.
  - r29 = sp_init, r31 = ra_init, all other registers 0.
  - data_rd_wr = 1; data_addr and data_out = 0.
- Phase sequencing after reset release: IF->ID->EX->ME->WB->IF, one clock each. Exactly 5 cycles per instruction for every opcode.
- instr_addr = PC, held constant across all five phases.
- IF: instr_in is captured into IR on the IF->ID edge. Memory must present the word by the end of IF.
- ID: decode; read rs and rt; sign- or zero-extend the 16-bit immediate.
- EX: ALU result and branch/jump decision.
- ME, loads/stores only:
  - data_addr = rs + sext(imm). Low 2 bits are passed unmodified; word access only.
  - data_rd_wr = 0 only during ME of SW; 1 in every other cycle.
  - data_out = rt value.
  - data_in is captured on the ME->WB edge.
- WB: register write on the WB->IF edge. PC update on the same edge.
- Required internal signals (the bench probes them hierarchically):
  - st_en: high only during ME of SW.
  - reg_wr_en: high only during WB of an instruction that writes a nonzero register.
  - reg_wr_num: 5-bit destination register.
  - reg_wr_data: 32-bit write value.
- r0 reads 0 always; writes to r0 are discarded and reg_wr_en stays low.
- Supported R-type (funct): SLL, SRL, SRA, ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, JR, JALR.
  - ADD/SUB behave as ADDU/SUBU; no overflow traps.
- Supported I/J-type: ADDIU, SLTI, SLTIU, ANDI, ORI, XORI (zero-extended), LUI, LW, SW, BEQ, BNE, J, JAL.
- Arithmetic: 32-bit wraparound. SLT/SLTI are signed, SLTU/SLTIU unsigned. Shifts use shamt[4:0].
- No branch delay slots; next PC:
  - Default: PC+4.
  - Taken branch: PC+4+(sext(imm)<<2).
  - J/JAL: {PC+4[31:28], target, 2'b00}.
  - JR/JALR: rs.
- JAL writes PC+4 to r31. JALR writes PC+4 to rd.
- Unknown opcode/funct executes as NOP: no write, no store, PC+4.
- Reset asserted mid-instruction: aborts immediately; no partial register write or store completes.

Test Plan:
- Reset release, pc_init=0x80020000: instr_addr=0x80020000 for 5 cycles, then 0x80020004; r29=sp_init, r31=0.
- ADDIU r2,r0,0x1234 then ADDU r3,r2,r2: WB shows write 0x00001234 to r2, then write 0x00002468 to r3; st_en never high.
- LUI r4,0x8003; ORI r4,r4,0x10; SW r3,0(r4); LW r5,0(r4):
  - ME of SW: data_rd_wr=0, data_addr=0x80030010, data_out=0x00002468.
  - LW WB: write 0x00002468 to r5.
- BEQ r0,r0,+2 at 0x80020000: next instr_addr 0x8002000C. BNE r0,r0 at same PC: next PC 0x80020004, no register write.
- JAL to target 0x80020100 from 0x80020010: r31=0x80020014, next PC 0x80020100. JR r31 returns to 0x80020014.
- ADDIU r0,r0,5 and an unknown opcode: reg_wr_en low, PC advances by 4. Reset asserted during ME of SW: store suppressed, PC=pc_init.
